// File: rtl/lcd_st7789v3_pkg.sv
// ----------------------------------------------------------------------------
// lcd_st7789v3_pkg
// Shared definitions for the ST7789V3 serial LCD driver and its receive-side
// monitor (lcd_spi_rx).
//   - ST7789V3 command codes used by the driver init sequence and bench checks
//   - rx_state_t: receive state encoding used by lcd_spi_rx
// ----------------------------------------------------------------------------
package lcd_st7789v3_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_NORON   = 8'h13;
    localparam logic [7:0] CMD_INVON   = 8'h21;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    // Plain vector encoding keeps the state register compatible with
    // existing tools that expect constant-coded states.
    typedef logic [0:0] rx_state_t;

    localparam rx_state_t RX_IDLE  = 1'b0;
    localparam rx_state_t RX_SHIFT = 1'b1;

endpackage

// File: rtl/lcd_sync_edge.sv
// ----------------------------------------------------------------------------
// lcd_sync_edge
// Brings one asynchronous bus input into the clk domain and flags its edges.
//
// Parameters:
//   SYNC_STAGES  number of synchronizer flops (2..3)
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   din   in   asynchronous input
//   sync  out  synchronized level
//   rise  out  1 for one cycle when sync goes 0 -> 1
//   fall  out  1 for one cycle when sync goes 1 -> 0
// ----------------------------------------------------------------------------
module lcd_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // All flops reset to 0: a CS line already low when reset is released
    // therefore produces no fall, so reception waits for a fresh CS fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/lcd_spi_rx.sv
// ----------------------------------------------------------------------------
// lcd_spi_rx
// Receive-side decoder / bus monitor for the 4-wire ST7789V3 serial LCD bus.
// Oversamples CS/SCL/SDA/DCX in the clk domain, deserializes bytes, tags
// them as command or parameter and presents them on a valid/ready stream.
//
// Optional feature macro: LCD_SPI_RX_CMD_TRACK_EN
//   defined   : cur_cmd / arg_idx track the owning command and parameter index
//   undefined : cur_cmd and arg_idx are tied to 0, no tracking registers
//
// Parameters:
//   SYNC_STAGES  synchronizer depth per bus input (2..3)
//   MSB_FIRST    1: first SCL bit is bit 7, 0: first bit is bit 0
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   lcd_cs       in   chip select, active low (async)
//   lcd_scl      in   serial clock, data sampled on rising edge (async)
//   lcd_sd       in   serial data
//   lcd_rs       in   D/CX, 0 = command, 1 = parameter
//   byte_valid   out  holding register full
//   byte_ready   in   consumer accepts byte when byte_valid && byte_ready
//   byte_data    out  received byte
//   byte_is_cmd  out  byte was received with rs = 0
//   cur_cmd      out  last command byte loaded
//   arg_idx      out  parameter index of byte_data, saturates at 63
//   overrun      out  sticky, a completed byte was dropped
//   frame_err    out  one-cycle pulse, CS deasserted mid-byte
//
// State table (rx_state):
//   state     | meaning
//   RX_IDLE   | CS high or no CS fall seen yet; bit counter held at 0
//   RX_SHIFT  | CS low; shifting bits on SCL rises, 8 rises = one byte
// ----------------------------------------------------------------------------
module lcd_spi_rx
    import lcd_st7789v3_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_cs,
    input  logic       lcd_scl,
    input  logic       lcd_sd,
    input  logic       lcd_rs,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] byte_data,
    output logic       byte_is_cmd,
    output logic [7:0] cur_cmd,
    output logic [5:0] arg_idx,
    output logic       overrun,
    output logic       frame_err
);

    logic cs_sync, cs_rise, cs_fall;
    logic scl_sync, scl_rise, scl_fall;
    logic sd_sync, sd_rise, sd_fall;
    logic rs_sync, rs_rise, rs_fall;

    lcd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .din  (lcd_cs),
        .sync (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    lcd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
        .clk  (clk),
        .rst  (rst),
        .din  (lcd_scl),
        .sync (scl_sync),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    lcd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
        .clk  (clk),
        .rst  (rst),
        .din  (lcd_sd),
        .sync (sd_sync),
        .rise (sd_rise),
        .fall (sd_fall)
    );

    lcd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rs (
        .clk  (clk),
        .rst  (rst),
        .din  (lcd_rs),
        .sync (rs_sync),
        .rise (rs_rise),
        .fall (rs_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{scl_sync, scl_fall, sd_rise, sd_fall, rs_rise, rs_fall};

    // ------------------------------------------------------------------
    // Deserializer
    // ------------------------------------------------------------------
    rx_state_t  rx_state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic       byte_done;
    logic [7:0] done_data;
    logic       done_rs;

    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST) begin
            shift_next = {shift_reg[6:0], sd_sync};
        end else begin
            shift_next = {sd_sync, shift_reg[7:1]};
        end
    end

    // byte_done/done_data form one pipeline stage between the 8th SCL rise
    // and the holding register load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            byte_done <= 1'b0;
            done_data <= 8'h00;
            done_rs   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt <= 3'd0;
                    if (cs_fall) begin
                        rx_state <= RX_SHIFT;
                    end
                end
                RX_SHIFT: begin
                    if (cs_sync) begin
                        // Partial byte is abandoned; only a mid-byte CS rise
                        // is an error.
                        rx_state  <= RX_IDLE;
                        bit_cnt   <= 3'd0;
                        frame_err <= cs_rise && (bit_cnt != 3'd0);
                    end else if (scl_rise) begin
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done <= 1'b1;
                            done_data <= shift_next;
                            done_rs   <= rs_sync;
                        end
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single-entry output holding register
    // ------------------------------------------------------------------
    logic pop;
    logic load;
    logic drop;

    assign pop  = byte_valid && byte_ready;
    assign load = byte_done && (!byte_valid || byte_ready);
    assign drop = byte_done && byte_valid && !byte_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_valid  <= 1'b0;
            byte_data   <= 8'h00;
            byte_is_cmd <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (load) begin
                byte_valid  <= 1'b1;
                byte_data   <= done_data;
                byte_is_cmd <= !done_rs;
            end else if (pop) begin
                byte_valid  <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command tracking, updated only when a byte is actually loaded
    // ------------------------------------------------------------------
`ifdef LCD_SPI_RX_CMD_TRACK_EN
    logic [5:0] next_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_cmd  <= 8'h00;
            arg_idx  <= 6'd0;
            next_idx <= 6'd0;
        end else if (load) begin
            if (!done_rs) begin
                cur_cmd  <= done_data;
                arg_idx  <= 6'd0;
                next_idx <= 6'd0;
            end else begin
                arg_idx <= next_idx;
                if (next_idx != 6'd63) begin
                    next_idx <= next_idx + 6'd1;
                end
            end
        end
    end
`else
    assign cur_cmd = 8'h00;
    assign arg_idx = 6'd0;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
`timescale 1ns/1ps
module tb_lcd_spi_rx;

    localparam int SYNC = 2;
`ifdef LCD_SPI_RX_CMD_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_cs = 1'b1;
    logic       lcd_scl = 1'b0;
    logic       lcd_sd = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       byte_ready = 1'b1;

    logic       byte_valid, byte_is_cmd, overrun, frame_err;
    logic [7:0] byte_data, cur_cmd;
    logic [5:0] arg_idx;

    logic       l_valid, l_is_cmd, l_overrun, l_frame_err;
    logic [7:0] l_data, l_cur_cmd;
    logic [5:0] l_arg_idx;

    int total = 0;
    int bad = 0;
    int n_frame = 0;

    logic [7:0] q_data[$];
    logic       q_cmd[$];
    logic [7:0] q_cur[$];
    logic [5:0] q_idx[$];
    logic [7:0] q_lsb[$];

    lcd_spi_rx #(.SYNC_STAGES(SYNC), .MSB_FIRST(1'b1)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_cs      (lcd_cs),
        .lcd_scl     (lcd_scl),
        .lcd_sd      (lcd_sd),
        .lcd_rs      (lcd_rs),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_data   (byte_data),
        .byte_is_cmd (byte_is_cmd),
        .cur_cmd     (cur_cmd),
        .arg_idx     (arg_idx),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    lcd_spi_rx #(.SYNC_STAGES(SYNC), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk         (clk),
        .rst         (rst),
        .lcd_cs      (lcd_cs),
        .lcd_scl     (lcd_scl),
        .lcd_sd      (lcd_sd),
        .lcd_rs      (lcd_rs),
        .byte_valid  (l_valid),
        .byte_ready  (byte_ready),
        .byte_data   (l_data),
        .byte_is_cmd (l_is_cmd),
        .cur_cmd     (l_cur_cmd),
        .arg_idx     (l_arg_idx),
        .overrun     (l_overrun),
        .frame_err   (l_frame_err)
    );

    always #5 clk = ~clk;

    // Accepted-byte capture; sampled mid-cycle, stimulus moves at posedge+1.
    always @(negedge clk) begin
        if (byte_valid && byte_ready) begin
            q_data.push_back(byte_data);
            q_cmd.push_back(byte_is_cmd);
            q_cur.push_back(cur_cmd);
            q_idx.push_back(arg_idx);
        end
        if (l_valid && byte_ready) q_lsb.push_back(l_data);
        if (frame_err) n_frame++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_cmd.delete();
        q_cur.delete();
        q_idx.delete();
        q_lsb.delete();
        n_frame = 0;
    endtask

    task automatic send_bit(input logic b);
        lcd_scl = 1'b0;
        lcd_sd  = b;
        tick(4);
        lcd_scl = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic rs);
        lcd_rs = rs;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic cs_start();
        lcd_cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        lcd_scl = 1'b0;
        tick(2);
        lcd_cs = 1'b1;
        tick(6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
        total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", byte_data); end
        total++; if (byte_is_cmd !== 1'b0) begin bad++; $display("FAIL reset_is_cmd: got %b want 0", byte_is_cmd); end
        total++; if (cur_cmd !== 8'h00) begin bad++; $display("FAIL reset_cur_cmd: got %h want 00", cur_cmd); end
        total++; if (arg_idx !== 6'd0) begin bad++; $display("FAIL reset_arg_idx: got %0d want 0", arg_idx); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        rst = 1'b0;
        tick(4);
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid: got %b want 0", byte_valid); end
    endtask

    // Parameter byte before any command, with the exact valid latency.
    task automatic test_latency();
        logic [7:0] v;
        v = 8'hA5;
        clear_mon();
        cs_start();
        lcd_rs = 1'b1;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        lcd_scl = 1'b0;
        lcd_sd  = v[0];
        tick(4);
        lcd_scl = 1'b1;
        tick(SYNC + 1);
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL latency_early: valid=%b want 0", byte_valid); end
        tick(1);
        total++; if (byte_valid !== 1'b1) begin bad++; $display("FAIL latency_on_time: valid=%b want 1", byte_valid); end
        total++; if (byte_data !== 8'hA5) begin bad++; $display("FAIL latency_data: got %h want a5", byte_data); end
        total++; if (byte_is_cmd !== 1'b0) begin bad++; $display("FAIL latency_is_cmd: got %b want 0", byte_is_cmd); end
        total++; if (cur_cmd !== 8'h00) begin bad++; $display("FAIL param_before_cmd_cur: got %h want 00", cur_cmd); end
        total++; if (arg_idx !== 6'd0) begin bad++; $display("FAIL param_before_cmd_idx: got %0d want 0", arg_idx); end
        tick(6);
        total++;
        if (q_lsb.size() != 1) begin
            bad++; $display("FAIL lsb_a5_count: got %0d want 1", q_lsb.size());
        end else if (q_lsb[0] !== 8'hA5) begin
            bad++; $display("FAIL lsb_a5_data: got %h want a5", q_lsb[0]);
        end
        cs_end();
    endtask

    task automatic test_cmd_params();
        logic [7:0] ed [5] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h87};
        logic       ec [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [5:0] ei [5] = '{6'd0, 6'd0, 6'd1, 6'd2, 6'd3};
        logic [7:0] exp_cur;
        logic [5:0] exp_idx;
        clear_mon();
        cs_start();
        send_byte(8'h2A, 1'b0);
        for (int i = 1; i < 5; i++) send_byte(ed[i], 1'b1);
        tick(6);
        cs_end();
        total++; if (n_frame != 0) begin bad++; $display("FAIL cmd_params_frame: got %0d pulses want 0", n_frame); end
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL cmd_params_drained: valid=%b want 0", byte_valid); end
        total++;
        if (q_data.size() != 5) begin
            bad++; $display("FAIL cmd_params_count: got %0d want 5", q_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_cur = TRACK ? 8'h2A : 8'h00;
                exp_idx = TRACK ? ei[i] : 6'd0;
                total++; if (q_data[i] !== ed[i]) begin bad++; $display("FAIL cmd_params_data[%0d]: got %h want %h", i, q_data[i], ed[i]); end
                total++; if (q_cmd[i] !== ec[i]) begin bad++; $display("FAIL cmd_params_is_cmd[%0d]: got %b want %b", i, q_cmd[i], ec[i]); end
                total++; if (q_cur[i] !== exp_cur) begin bad++; $display("FAIL cmd_params_cur[%0d]: got %h want %h", i, q_cur[i], exp_cur); end
                total++; if (q_idx[i] !== exp_idx) begin bad++; $display("FAIL cmd_params_idx[%0d]: got %0d want %0d", i, q_idx[i], exp_idx); end
            end
        end
    endtask

    task automatic test_bit_order();
        clear_mon();
        cs_start();
        send_byte(8'h01, 1'b0);
        tick(6);
        cs_end();
        total++;
        if (q_data.size() != 1 || q_lsb.size() != 1) begin
            bad++; $display("FAIL bit_order_count: got %0d/%0d want 1/1", q_data.size(), q_lsb.size());
        end else begin
            total++; if (q_data[0] !== 8'h01) begin bad++; $display("FAIL bit_order_msb: got %h want 01", q_data[0]); end
            total++; if (q_lsb[0] !== 8'h80) begin bad++; $display("FAIL bit_order_lsb: got %h want 80", q_lsb[0]); end
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        cs_start();
        lcd_rs = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        lcd_scl = 1'b0;
        tick(2);
        lcd_cs = 1'b1;
        tick(SYNC);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_err_early: got %b want 0", frame_err); end
        tick(1);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL frame_err_pulse: got %b want 1", frame_err); end
        tick(1);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_err_width: got %b want 0", frame_err); end
        tick(6);
        total++; if (n_frame != 1) begin bad++; $display("FAIL frame_err_count: got %0d want 1", n_frame); end
        total++; if (q_data.size() != 0) begin bad++; $display("FAIL frame_err_no_byte: got %0d bytes want 0", q_data.size()); end
        cs_start();
        send_byte(8'h29, 1'b0);
        tick(6);
        cs_end();
        total++;
        if (q_data.size() != 1) begin
            bad++; $display("FAIL frame_recover_count: got %0d want 1", q_data.size());
        end else begin
            total++; if (q_data[0] !== 8'h29) begin bad++; $display("FAIL frame_recover_data: got %h want 29", q_data[0]); end
            total++; if (q_cmd[0] !== 1'b1) begin bad++; $display("FAIL frame_recover_is_cmd: got %b want 1", q_cmd[0]); end
        end
        total++; if (n_frame != 1) begin bad++; $display("FAIL frame_recover_pulses: got %0d want 1", n_frame); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_cur;
        exp_cur = TRACK ? 8'h11 : 8'h00;
        clear_mon();
        byte_ready = 1'b0;
        cs_start();
        send_byte(8'h11, 1'b0);
        tick(6);
        total++; if (byte_valid !== 1'b1) begin bad++; $display("FAIL overrun_first_valid: got %b want 1", byte_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_early: got %b want 0", overrun); end
        send_byte(8'h13, 1'b0);
        tick(6);
        total++; if (byte_data !== 8'h11) begin bad++; $display("FAIL overrun_held_data: got %h want 11", byte_data); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
        total++; if (cur_cmd !== exp_cur) begin bad++; $display("FAIL overrun_cur_cmd: got %h want %h", cur_cmd, exp_cur); end
        byte_ready = 1'b1;
        tick(4);
        cs_end();
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL overrun_drained: valid=%b want 0", byte_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
        total++;
        if (q_data.size() != 1) begin
            bad++; $display("FAIL overrun_pop_count: got %0d want 1", q_data.size());
        end else if (q_data[0] !== 8'h11) begin
            bad++; $display("FAIL overrun_pop_data: got %h want 11", q_data[0]);
        end
    endtask

    task automatic test_saturation();
        logic [5:0] exp_idx;
        clear_mon();
        cs_start();
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < 70; i++) send_byte(8'(i + 3), 1'b1);
        tick(6);
        cs_end();
        total++;
        if (q_data.size() != 71) begin
            bad++; $display("FAIL sat_count: got %0d want 71", q_data.size());
        end else begin
            for (int k = 1; k <= 70; k++) begin
                exp_idx = !TRACK ? 6'd0 : ((k - 1) > 63) ? 6'd63 : 6'(k - 1);
                total++; if (q_idx[k] !== exp_idx) begin bad++; $display("FAIL sat_idx[%0d]: got %0d want %0d", k, q_idx[k], exp_idx); end
            end
            total++; if (q_data[70] !== 8'd72) begin bad++; $display("FAIL sat_last_data: got %h want 48", q_data[70]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_cur;
        exp_cur = TRACK ? 8'h21 : 8'h00;
        clear_mon();
        cs_start();
        lcd_rs = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        rst = 1'b1;
        tick(2);
        total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", byte_valid); end
        total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data: got %h want 00", byte_data); end
        total++; if (cur_cmd !== 8'h00) begin bad++; $display("FAIL rst_mid_cur_cmd: got %h want 00", cur_cmd); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_overrun: got %b want 0", overrun); end
        rst = 1'b0;
        tick(4);
        lcd_scl = 1'b0;
        lcd_cs = 1'b1;
        tick(6);
        total++; if (n_frame != 0) begin bad++; $display("FAIL rst_mid_frame: got %0d pulses want 0", n_frame); end
        cs_start();
        send_byte(8'h21, 1'b0);
        tick(6);
        cs_end();
        total++;
        if (q_data.size() != 1) begin
            bad++; $display("FAIL rst_recover_count: got %0d want 1", q_data.size());
        end else begin
            total++; if (q_data[0] !== 8'h21) begin bad++; $display("FAIL rst_recover_data: got %h want 21", q_data[0]); end
            total++; if (q_cmd[0] !== 1'b1) begin bad++; $display("FAIL rst_recover_is_cmd: got %b want 1", q_cmd[0]); end
            total++; if (q_cur[0] !== exp_cur) begin bad++; $display("FAIL rst_recover_cur: got %h want %h", q_cur[0], exp_cur); end
            total++; if (q_idx[0] !== 6'd0) begin bad++; $display("FAIL rst_recover_idx: got %0d want 0", q_idx[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_cmd_params();
        test_bit_order();
        test_frame_err();
        test_overrun();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
